// File: rtl/dmem_responder.sv
// dmem_responder: target side of the Memory-stage load/store interface.
// Accepts one request at a time, waits LATENCY cycles, performs the access,
// then pulses o_RValid (load) or o_WAck (store) for one cycle.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN. When defined, a request whose
// byte address is not word aligned is answered with o_Err=1 and has no effect
// on memory or o_D. When undefined, o_Err stays 0 and i_A[1:0] is ignored.
//
// Handshake: a request is accepted on a rising edge where i_Req=1 and
// o_Ready=1. o_Ready is a registered output, high only in IDLE, so an
// i_Req seen while not ready is simply dropped and must be held by the
// requester until accepted.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_Req,
    input  logic        i_WE,
    input  logic [31:0] i_A,
    input  logic [31:0] i_D,
    input  logic [3:0]  i_BE,
    output logic        o_Ready,
    output logic        o_RValid,
    output logic        o_WAck,
    output logic [31:0] o_D,
    output logic        o_Busy,
    output logic        o_Err
);

    localparam int             DEPTH       = 2 ** ADDR_W;
    localparam logic [3:0]     CNT_INIT    = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic                r_mis;
    logic                r_ready;
    logic                r_busy;
    logic                r_rvalid;
    logic                r_wack;
    logic                r_err;
    logic [31:0]         r_d;
    logic [31:0]         r_mem [DEPTH];

    logic                w_accept;
    logic                w_mis;
    logic                w_unused_addr;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_mis = (i_A[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    // Address bits above the word index alias away; byte-offset bits only
    // matter when the misalignment trap is compiled in.
    assign w_unused_addr = ^{i_A[31:ADDR_W+2], i_A[1:0]};

    assign w_accept = (r_state == S_IDLE) && i_Req && r_ready;

    // Single FSM: handshake, wait countdown, memory access and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_idx    <= '0;
            r_wdata  <= 32'd0;
            r_be     <= 4'd0;
            r_mis    <= 1'b0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_rvalid <= 1'b0;
            r_wack   <= 1'b0;
            r_err    <= 1'b0;
            r_d      <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we    <= i_WE;
                        r_idx   <= i_A[ADDR_W+1:2];
                        r_wdata <= i_D;
                        r_be    <= i_BE;
                        r_mis   <= w_mis;
                        r_cnt   <= CNT_INIT;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        // Access edge: a trapped (misaligned) request touches nothing.
                        if (!r_mis) begin
                            if (r_we) begin
                                for (int b = 0; b < 4; b++) begin
                                    if (r_be[b]) begin
                                        r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                                    end
                                end
                            end else begin
                                r_d <= r_mem[r_idx];
                            end
                        end
                        r_rvalid <= ~r_we;
                        r_wack   <= r_we;
                        r_err    <= r_mis;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_rvalid <= 1'b0;
                    r_wack   <= 1'b0;
                    r_err    <= 1'b0;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Ready  = r_ready;
    assign o_Busy   = r_busy;
    assign o_RValid = r_rvalid;
    assign o_WAck   = r_wack;
    assign o_Err    = r_err;
    assign o_D      = r_d;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (ADDR_W=10, LATENCY=2).
// Expected values come from a word-array reference model of the memory plus
// the documented response timing (response LAT+1 cycles after accept).
module tb_dmem_responder;
    localparam int AW  = 10;
    localparam int LAT = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        i_Req, i_WE;
    logic [31:0] i_A, i_D;
    logic [3:0]  i_BE;
    logic        o_Ready, o_RValid, o_WAck, o_Busy, o_Err;
    logic [31:0] o_D;

    int tests_run = 0;
    int failed    = 0;

    // reference model state
    logic [31:0] ref_mem [1024];
    logic [31:0] ref_d;
    logic [31:0] exp_q[$];

    dmem_responder #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .Clk(Clk), .Reset(Reset), .i_Req(i_Req), .i_WE(i_WE), .i_A(i_A),
        .i_D(i_D), .i_BE(i_BE), .o_Ready(o_Ready), .o_RValid(o_RValid),
        .o_WAck(o_WAck), .o_D(o_D), .o_Busy(o_Busy), .o_Err(o_Err)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference: apply one access; returns the o_D / o_Err expected at the response.
    task automatic model_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] be, output logic [31:0] exp_d, output logic exp_err);
        int  idx;
        bit  mis;
        idx = int'((a / 4) % 1024);
`ifdef DMEM_MISALIGN_TRAP_EN
        mis = (a % 4) != 0;
`else
        mis = 1'b0;
`endif
        if (!mis) begin
            if (we) begin
                for (int n = 0; n < 4; n++)
                    if (be[n]) ref_mem[idx][8*n +: 8] = d[8*n +: 8];
            end else begin
                ref_d = ref_mem[idx];
            end
        end
        exp_d   = ref_d;
        exp_err = mis;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
        ref_d = 32'd0;
    endtask

    // Driver: issue one request from a negedge and observe a fixed window.
    task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          output bit timeout, output int pulse_cyc, output int rv_n, output int wa_n,
                          output int busy_n, output int rdy_lo_n, output logic [31:0] rdata, output logic err);
        int w;
        timeout = 0; pulse_cyc = -1; rv_n = 0; wa_n = 0; busy_n = 0; rdy_lo_n = 0;
        rdata = 32'd0; err = 1'b0; w = 0;
        while (o_Ready !== 1'b1 && w < 40) begin @(negedge Clk); w++; end
        if (o_Ready !== 1'b1) begin timeout = 1; return; end
        i_Req = 1'b1; i_WE = we; i_A = a; i_D = d; i_BE = be;
        @(negedge Clk);
        i_Req = 1'b0; i_WE = 1'($urandom); i_A = $urandom; i_D = $urandom; i_BE = 4'($urandom);
        for (int k = 1; k <= LAT + 2; k++) begin
            if (o_Busy === 1'b1) busy_n++;
            if (o_Ready === 1'b0) rdy_lo_n++;
            if (o_RValid === 1'b1) rv_n++;
            if (o_WAck === 1'b1) wa_n++;
            if ((o_RValid === 1'b1 || o_WAck === 1'b1) && pulse_cyc < 0) begin
                pulse_cyc = k; rdata = o_D; err = o_Err;
            end
            @(negedge Clk);
        end
        if (pulse_cyc < 0) rdata = o_D;
    endtask

    task automatic test_reset();
        Reset = 1'b1; i_Req = 1'b0; i_WE = 1'b0; i_A = '0; i_D = '0; i_BE = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        tests_run++; if (o_Ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b expected 1", o_Ready); end
        tests_run++; if (o_Busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b expected 0", o_Busy); end
        tests_run++; if (o_RValid !== 1'b0 || o_WAck !== 1'b0 || o_Err !== 1'b0) begin failed++; $display("FAIL reset_pulses: got rv=%b wa=%b err=%b expected 0", o_RValid, o_WAck, o_Err); end
        tests_run++; if (o_D !== 32'd0) begin failed++; $display("FAIL reset_d: got %h expected 00000000", o_D); end
    endtask

    task automatic test_store_load();
        bit to; int pc, rv, wa, bz, rl; logic [31:0] rd, ed; logic er, ee;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, to, pc, rv, wa, bz, rl, rd, er);
        model_access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ed, ee);
        tests_run++; if (to) begin failed++; $display("FAIL store_ready_timeout: got ready=%b expected 1", o_Ready); end
        tests_run++; if (bz !== LAT + 1) begin failed++; $display("FAIL store_busy_cycles: got %0d expected %0d", bz, LAT + 1); end
        tests_run++; if (rl !== LAT + 1) begin failed++; $display("FAIL store_ready_low: got %0d expected %0d", rl, LAT + 1); end
        tests_run++; if (pc !== LAT + 1 || wa !== 1 || rv !== 0) begin failed++; $display("FAIL store_ack: got cyc=%0d wack=%0d rvalid=%0d expected cyc=%0d wack=1 rvalid=0", pc, wa, rv, LAT + 1); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, to, pc, rv, wa, bz, rl, rd, er);
        model_access(1'b0, 32'h10, 32'h0, 4'h0, ed, ee);
        tests_run++; if (pc !== LAT + 1 || rv !== 1 || wa !== 0) begin failed++; $display("FAIL load_pulse: got cyc=%0d rvalid=%0d wack=%0d expected cyc=%0d rvalid=1 wack=0", pc, rv, wa, LAT + 1); end
        tests_run++; if (rd !== 32'hDEADBEEF) begin failed++; $display("FAIL load_data: got %h expected deadbeef", rd); end
        tests_run++; if (er !== 1'b0) begin failed++; $display("FAIL load_err: got %b expected 0", er); end
    endtask

    task automatic test_partial_store();
        bit to; int pc, rv, wa, bz, rl; logic [31:0] rd, ed; logic er, ee;
        do_req(1'b1, 32'h10, 32'h11223344, 4'b0101, to, pc, rv, wa, bz, rl, rd, er);
        model_access(1'b1, 32'h10, 32'h11223344, 4'b0101, ed, ee);
        tests_run++; if (rd !== 32'hDEADBEEF) begin failed++; $display("FAIL store_keeps_d: got %h expected deadbeef", rd); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, to, pc, rv, wa, bz, rl, rd, er);
        model_access(1'b0, 32'h10, 32'h0, 4'h0, ed, ee);
        tests_run++; if (rd !== 32'hDE22BE44) begin failed++; $display("FAIL partial_store: got %h expected de22be44", rd); end
        do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, to, pc, rv, wa, bz, rl, rd, er);
        model_access(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, ed, ee);
        tests_run++; if (wa !== 1 || pc !== LAT + 1) begin failed++; $display("FAIL be0_ack: got wack=%0d cyc=%0d expected 1 %0d", wa, pc, LAT + 1); end
        do_req(1'b0, 32'h10, 32'h0, 4'h0, to, pc, rv, wa, bz, rl, rd, er);
        model_access(1'b0, 32'h10, 32'h0, 4'h0, ed, ee);
        tests_run++; if (rd !== 32'hDE22BE44) begin failed++; $display("FAIL be0_unchanged: got %h expected de22be44", rd); end
    endtask

    task automatic test_alias();
        bit to; int pc, rv, wa, bz, rl; logic [31:0] rd, ed; logic er, ee;
        do_req(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, to, pc, rv, wa, bz, rl, rd, er);
        model_access(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, ed, ee);
        do_req(1'b0, 32'h0000, 32'h0, 4'h0, to, pc, rv, wa, bz, rl, rd, er);
        model_access(1'b0, 32'h0000, 32'h0, 4'h0, ed, ee);
        tests_run++; if (rd !== 32'hCAFEF00D) begin failed++; $display("FAIL alias: got %h expected cafef00d", rd); end
    endtask

    task automatic test_back_to_back();
        bit to; int pc, rv, wa, bz, rl; logic [31:0] rd, ed; logic er, ee;
        int acc[$]; logic [31:0] rd_q[$]; int bad_rdy; int spacing; logic [31:0] e0, e1;
        do_req(1'b1, 32'h40, 32'hA0A0A0A0, 4'hF, to, pc, rv, wa, bz, rl, rd, er);
        model_access(1'b1, 32'h40, 32'hA0A0A0A0, 4'hF, ed, ee);
        do_req(1'b1, 32'h44, 32'hB1B1B1B1, 4'hF, to, pc, rv, wa, bz, rl, rd, er);
        model_access(1'b1, 32'h44, 32'hB1B1B1B1, 4'hF, ed, ee);
        model_access(1'b0, 32'h40, 32'h0, 4'h0, e0, ee);
        model_access(1'b0, 32'h44, 32'h0, 4'h0, e1, ee);
        bad_rdy = 0;
        i_Req = 1'b1; i_WE = 1'b0; i_A = 32'h40; i_BE = 4'hF;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (acc.size() == 1) i_A = 32'h44;
            if (acc.size() == 2) i_Req = 1'b0;
            if (o_Ready !== ~o_Busy) bad_rdy++;
            if (o_RValid === 1'b1) rd_q.push_back(o_D);
            if (o_Ready === 1'b1 && i_Req === 1'b1) acc.push_back(cyc);
            @(negedge Clk);
        end
        i_Req = 1'b0;
        spacing = (acc.size() >= 2) ? acc[1] - acc[0] : -1;
        tests_run++; if (acc.size() !== 2) begin failed++; $display("FAIL b2b_accepts: got %0d expected 2", acc.size()); end
        tests_run++; if (spacing !== LAT + 2) begin failed++; $display("FAIL b2b_spacing: got %0d expected %0d", spacing, LAT + 2); end
        tests_run++; if (bad_rdy !== 0) begin failed++; $display("FAIL b2b_ready_vs_busy: got %0d bad cycles expected 0", bad_rdy); end
        tests_run++; if (rd_q.size() !== 2) begin failed++; $display("FAIL b2b_responses: got %0d expected 2", rd_q.size()); end
        else begin
            tests_run++; if (rd_q[0] !== e0 || rd_q[1] !== e1) begin failed++; $display("FAIL b2b_data: got %h %h expected %h %h", rd_q[0], rd_q[1], e0, e1); end
        end
    endtask

    task automatic test_reset_mid();
        bit to; int pc, rv, wa, bz, rl; logic [31:0] rd, ed; logic er, ee; int wack_n;
        i_Req = 1'b1; i_WE = 1'b1; i_A = 32'h20; i_D = 32'h12345678; i_BE = 4'hF;
        @(negedge Clk);
        i_Req = 1'b0;
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        tests_run++; if (o_Ready !== 1'b1 || o_Busy !== 1'b0) begin failed++; $display("FAIL midreset_state: got ready=%b busy=%b expected 1 0", o_Ready, o_Busy); end
        wack_n = 0;
        for (int k = 0; k < LAT + 3; k++) begin
            if (o_WAck === 1'b1) wack_n++;
            @(negedge Clk);
        end
        tests_run++; if (wack_n !== 0) begin failed++; $display("FAIL midreset_no_ack: got %0d expected 0", wack_n); end
        do_req(1'b0, 32'h20, 32'h0, 4'h0, to, pc, rv, wa, bz, rl, rd, er);
        model_access(1'b0, 32'h20, 32'h0, 4'h0, ed, ee);
        tests_run++; if (rd !== 32'h00000000) begin failed++; $display("FAIL midreset_not_committed: got %h expected 00000000", rd); end
    endtask

    task automatic test_misalign();
        bit to; int pc, rv, wa, bz, rl; logic [31:0] rd, ed; logic er, ee;
        do_req(1'b1, 32'h20, 32'h5A5AA5A5, 4'hF, to, pc, rv, wa, bz, rl, rd, er);
        model_access(1'b1, 32'h20, 32'h5A5AA5A5, 4'hF, ed, ee);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, to, pc, rv, wa, bz, rl, rd, er);
        model_access(1'b0, 32'h10, 32'h0, 4'h0, ed, ee);
        do_req(1'b0, 32'h22, 32'h0, 4'h0, to, pc, rv, wa, bz, rl, rd, er);
        model_access(1'b0, 32'h22, 32'h0, 4'h0, ed, ee);
        tests_run++; if (rv !== 1 || pc !== LAT + 1) begin failed++; $display("FAIL misalign_rvalid: got rv=%0d cyc=%0d expected 1 %0d", rv, pc, LAT + 1); end
        tests_run++; if (er !== ee) begin failed++; $display("FAIL misalign_err: got %b expected %b", er, ee); end
        tests_run++; if (rd !== ed) begin failed++; $display("FAIL misalign_data: got %h expected %h", rd, ed); end
    endtask

    task automatic test_random();
        bit to; int pc, rv, wa, bz, rl; logic [31:0] rd, ed, a, d, exp_d; logic er, ee, we; logic [3:0] be;
        int bad;
        bad = 0;
        for (int t = 0; t < 60; t++) begin
            we = 1'($urandom);
            a  = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 7)) << 2);
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
            d  = $urandom;
            be = 4'($urandom);
            model_access(we, a, d, be, ed, ee);
            exp_q.push_back(ed);
            do_req(we, a, d, be, to, pc, rv, wa, bz, rl, rd, er);
            exp_d = exp_q.pop_front();
            tests_run++;
            if (to || pc !== LAT + 1 || rv !== int'(!we) || wa !== int'(we) || er !== ee || rd !== exp_d) begin
                failed++; bad++;
                $display("FAIL random_txn%0d: got cyc=%0d rv=%0d wa=%0d err=%b d=%h expected cyc=%0d we=%b err=%b d=%h",
                         t, pc, rv, wa, er, rd, LAT + 1, we, ee, exp_d);
            end
        end
    endtask

    initial begin
        @(negedge Clk);
        test_reset();
        test_store_load();
        test_partial_store();
        test_alias();
        test_back_to_back();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
